// File: rtl/openhw_ram_fifo.sv
// openhw_ram_fifo: first-word-fall-through FIFO on a 1R1W byte-enable SRAM, 2-entry registered output skid.
// Latency: 1 cycle push->out_valid from empty (skid bypass); SRAM path adds the 1-cycle flopped read.
// Backpressure: in_ready = ~full (capacity DEPTH+2), low during reset; optional almost_full via RAM_FIFO_AFULL_EN.

package openhw_ram_fifo_pkg;
    // Subset of the core configuration consumed by the RAM wrappers.
    typedef struct packed {
        logic USE_SRAM;   // 1: foundry macro, 0: behavioural model
    } cvw_t;
endpackage

// openhw_ram2p1r1wbe: two-port SRAM, port 1 read (flopped address), port 2 byte-enable write.
// Latency: rd1 valid the cycle after ce1; rd1 holds while ce1=0.
// Backpressure: none, one read and one write per cycle.
module openhw_ram2p1r1wbe #(
    parameter openhw_ram_fifo_pkg::cvw_t P = '0,
    parameter int DEPTH = 1024,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     ce1,
    input  logic [$clog2(DEPTH)-1:0] ra1,
    output logic [WIDTH-1:0]         rd1,
    input  logic                     ce2,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] wa2,
    input  logic [WIDTH-1:0]         wd2,
    input  logic [WIDTH/8-1:0]       bwe2
);
    logic [WIDTH-1:0] mem [DEPTH];

    // The compiled macros only come in 64-bit multiples and always use byte lanes.
    if ((P.USE_SRAM && (WIDTH % 64) != 0) || (WIDTH % 8) != 0) begin : g_cfg_err
        $error("openhw_ram2p1r1wbe: unsupported WIDTH for this configuration");
    end

    // Registered read and byte-masked write; a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (ce1) rd1 <= mem[ra1];
        if (ce2 & we2) begin
            for (int i = 0; i < WIDTH/8; i++) begin
                if (bwe2[i]) mem[wa2][i*8 +: 8] <= wd2[i*8 +: 8];
            end
        end
    end
endmodule

module openhw_ram_fifo #(
    parameter openhw_ram_fifo_pkg::cvw_t P = '0,
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 1024,
    parameter int AFULL_LVL = DEPTH - 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(DEPTH+3)-1:0]    count
`ifdef RAM_FIFO_AFULL_EN
    ,
    output logic                          almost_full
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+3);
    localparam logic [CW-1:0] CAP = CW'(DEPTH + 2);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LVL > DEPTH + 2) begin : g_cfg_err
        $error("openhw_ram_fifo: DEPTH must be a power of two >= 4 and AFULL_LVL <= DEPTH+2");
    end

    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      ram_cnt;
    logic             rd_inflight;
    logic [1:0]       skid_cnt;
    logic [WIDTH-1:0] skid0, skid1;
    logic [WIDTH-1:0] rd1;

    logic             push, pop, bypass, ram_wr, rd_issue, fill;
    logic [1:0]       skid_after_pop;
    logic [2:0]       occ_after_pop;
    logic [WIDTH-1:0] fill_dat;
    logic [WIDTH-1:0] skid0_n, skid1_n;
    logic [CW-1:0]    count_n;

    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = skid0;
    assign in_ready  = reset_n & (count != CAP);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready;

    // Bypass only when nothing older sits in the SRAM or on the read port.
    assign skid_after_pop = skid_cnt - {1'b0, pop};
    assign bypass   = push & (ram_cnt == '0) & ~rd_inflight & (skid_after_pop != 2'd2);
    assign ram_wr   = push & ~bypass;
    // Keep skid + in-flight at 2 so the consumer never sees a bubble while the SRAM has data.
    assign occ_after_pop = {1'b0, skid_after_pop} + {2'b00, rd_inflight};
    assign rd_issue = (ram_cnt != '0) & (occ_after_pop < 3'd2);
    // Capture and bypass are exclusive: bypass needs ~rd_inflight.
    assign fill     = bypass | rd_inflight;
    assign fill_dat = rd_inflight ? rd1 : in_data;
    assign count_n  = count + CW'(push) - CW'(pop);

    // Skid next-state: shift on pop, then drop new data into the first free slot.
    always_comb begin
        skid0_n = skid0;
        skid1_n = skid1;
        if (pop) skid0_n = skid1;
        if (fill) begin
            if (skid_after_pop == 2'd0) skid0_n = fill_dat;
            else                        skid1_n = fill_dat;
        end
    end

    // Control state; reset also drops any in-flight read so its data is never captured.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            skid_cnt    <= 2'd0;
            count       <= '0;
        end else begin
            if (ram_wr)   wptr <= wptr + 1'b1;
            if (rd_issue) rptr <= rptr + 1'b1;
            ram_cnt     <= ram_cnt + (AW+1)'(ram_wr) - (AW+1)'(rd_issue);
            rd_inflight <= rd_issue;
            skid_cnt    <= skid_after_pop + {1'b0, fill};
            count       <= count_n;
        end
    end

    // Skid data registers need no reset; skid_cnt qualifies them.
    always_ff @(posedge clk) begin
        skid0 <= skid0_n;
        skid1 <= skid1_n;
    end

`ifdef RAM_FIFO_AFULL_EN
    // Registered from next-cycle occupancy so it lines up with count.
    always_ff @(posedge clk) begin
        if (!reset_n) almost_full <= 1'b0;
        else          almost_full <= (int'(count_n) >= AFULL_LVL);
    end
`endif

    openhw_ram2p1r1wbe #(.P(P), .DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk  (clk),
        .ce1  (rd_issue),
        .ra1  (rptr),
        .rd1  (rd1),
        .ce2  (ram_wr),
        .we2  (ram_wr),
        .wa2  (wptr),
        .wd2  (in_data),
        .bwe2 ({(WIDTH/8){1'b1}})
    );

`ifndef SYNTHESIS
    // Bookkeeping sanity: no pop from an empty skid, SRAM and skid never overfill.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(pop && !out_valid)) else $error("pop while out_valid=0");
            assert (ram_cnt <= (AW+1)'(DEPTH)) else $error("ram_cnt exceeds DEPTH");
            assert (skid_cnt <= 2'd2) else $error("skid overflow");
        end
    end
`endif
endmodule

// File: tb/tb_openhw_ram_fifo.sv
// tb_openhw_ram_fifo: scoreboard bench for openhw_ram_fifo (reduced DEPTH to keep runtime short).
// Latency: inputs driven at negedge, handshakes evaluated 1ns later, outputs compared against a queue.
// Backpressure: random and held out_ready/in_valid patterns, including fill to capacity.
module tb_openhw_ram_fifo;
    localparam int WIDTH     = 64;
    localparam int DEPTH     = 64;
    localparam int AFULL_LVL = 60;
    localparam int CAP       = DEPTH + 2;
    localparam int CW        = $clog2(DEPTH+3);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
`ifdef RAM_FIFO_AFULL_EN
    logic             almost_full;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] sb [$];

    openhw_ram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef RAM_FIFO_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check occupancy, score the handshakes, wait for next negedge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        chk("count", 64'(count), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(reset_n && (sb.size() < CAP)));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else                chk("out_data", out_data, sb.pop_front());
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 4*CAP + 20 && sb.size() != 0; k++) step(1'b0, '0, 1'b1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_count", 64'(count), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef RAM_FIFO_AFULL_EN
        chk("rst_afull", 64'(almost_full), 64'd0);
`endif
        reset_n = 1'b1;

        // Single push from empty: visible one cycle later.
        step(1'b1, 64'hA5, 1'b0);
        chk("single_vld", 64'(out_valid), 64'd1);
        chk("single_dat", out_data, 64'hA5);
        chk("single_cnt", 64'(count), 64'd1);
        step(1'b0, '0, 1'b1);
        chk("single_pop_cnt", 64'(count), 64'd0);
        chk("single_pop_vld", 64'(out_valid), 64'd0);

        // Fill past capacity with the consumer stalled; extra pushes must be refused.
        for (int i = 0; i < CAP + 2; i++) step(1'b1, 64'(i), 1'b0);
        chk("fill_cnt", 64'(count), 64'(CAP));
        chk("fill_rdy", 64'(in_ready), 64'd0);
        for (int i = 0; i < CAP; i++) begin
            chk("drain_no_bubble", 64'(out_valid), 64'd1);
            step(1'b0, '0, 1'b1);
        end
        chk("fill_drained", 64'(count), 64'd0);

        // Streaming push+pop every cycle: occupancy stays in the skid.
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 64'h1000 + 64'(i), 1'b1);
            chk("stream_cnt_le2", 64'(count <= CW'(2)), 64'd1);
        end
        drain();

        // Random valid/ready, 50% each.
        for (int i = 0; i < 12000; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        drain();

        // Reset with SRAM data queued and a read in flight.
        for (int i = 0; i < 40; i++) step(1'b1, 64'h5000 + 64'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        reset_n = 1'b0;
        step(1'b0, '0, 1'b0);
        sb.delete();
        reset_n = 1'b1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_vld", 64'(out_valid), 64'd0);
        step(1'b1, 64'h1, 1'b0);
        chk("midrst_first", out_data, 64'h1);
        step(1'b0, '0, 1'b1);
        chk("midrst_empty", 64'(count), 64'd0);

`ifdef RAM_FIFO_AFULL_EN
        for (int i = 0; i < AFULL_LVL - 1; i++) step(1'b1, 64'(i), 1'b0);
        chk("afull_below", 64'(almost_full), 64'd0);
        step(1'b1, 64'hFF, 1'b0);
        chk("afull_at", 64'(almost_full), 64'd1);
        step(1'b0, '0, 1'b1);
        chk("afull_after_pop", 64'(almost_full), 64'd0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
